// File: rtl/cart_arb_pkg.sv
// Shared constants for the cart memory arbiter: requester indices, select
// encodings and the open-bus read value.
package cart_arb_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_PPU  = 0;
  localparam int REQ_CPU  = 1;
  localparam int REQ_HOST = 2;

  // Select field layout is {prg, chr, ram}.
  localparam logic [2:0] SEL_PRG = 3'b100;
  localparam logic [2:0] SEL_CHR = 3'b010;
  localparam logic [2:0] SEL_RAM = 3'b001;

  localparam logic [7:0] OPEN_BUS_DFLT = 8'hFF;

  function automatic logic sel_legal(input logic [2:0] s);
    return (s == SEL_PRG) || (s == SEL_CHR) || (s == SEL_RAM);
  endfunction

endpackage

// File: rtl/cart_arb_starve_ctr.sv
// Saturating wait counter for one requester; promoted is high once the
// requester has waited LIMIT counted cycles without a grant.
module cart_arb_starve_ctr #(
  parameter int LIMIT = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic pending,
  input  logic granted,
  output logic promoted
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and evaluation order cannot change results.
  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (!pending || granted)
      count <= '0;
    else if (enable && (count != CW'(LIMIT)))
      count <= count + 1'b1;
  end

  assign promoted = (count == CW'(LIMIT));

endmodule

// File: rtl/cart_mem_arbiter.sv
// Three-way arbiter for the single-ported cart memory (PPU, CPU, host) with
// anti-starvation promotion. Define CART_ARB_STATS_EN to add stat counters.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int         ADDR_W       = 21,
  parameter int         STARVE_LIMIT = 8,
  parameter logic [7:0] OPEN_BUS     = OPEN_BUS_DFLT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cart_ready,
  input  logic [2:0]            req,
  input  logic [2:0]            we,
  input  logic [8:0]            sel,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [23:0]           wdata,
  output logic [2:0]            ack,
  output logic [2:0]            rvalid,
  output logic [7:0]            rdata,
  output logic [ADDR_W-1:0]     mem_address,
  output logic                  mem_prg_sel,
  output logic                  mem_chr_sel,
  output logic                  mem_ram_sel,
  output logic                  mem_rden,
  output logic                  mem_wren,
  output logic [7:0]            mem_write_data,
  input  logic [7:0]            mem_read_data
`ifdef CART_ARB_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [15:0]           stat_conflicts,
  output logic [15:0]           stat_promotions
`endif
);

  logic              cpu_prom, host_prom;
  logic [2:0]        grant;
  logic              win_prom;
  logic              win_we;
  logic [2:0]        win_sel;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0]        win_wdata;
  logic              win_legal;

  logic [2:0]        iss_rd_grant;
  logic              iss_legal;
  logic [2:0]        ret_rvalid;
  logic              ret_legal;
  logic [7:0]        rdata_q;

  cart_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_cpu (
    .clock    (clock),
    .reset    (reset),
    .enable   (cart_ready),
    .pending  (req[REQ_CPU]),
    .granted  (grant[REQ_CPU]),
    .promoted (cpu_prom)
  );

  cart_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve_host (
    .clock    (clock),
    .reset    (reset),
    .enable   (cart_ready),
    .pending  (req[REQ_HOST]),
    .granted  (grant[REQ_HOST]),
    .promoted (host_prom)
  );

  // Promotion is qualified by req: a counter still reads LIMIT in the cycle
  // its requester withdraws.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant    = '0;
    win_prom = 1'b0;
    if (cart_ready) begin
      if (req[REQ_CPU] && cpu_prom) begin
        grant[REQ_CPU] = 1'b1;
        win_prom       = 1'b1;
      end else if (req[REQ_HOST] && host_prom) begin
        grant[REQ_HOST] = 1'b1;
        win_prom        = 1'b1;
      end else if (req[REQ_PPU]) begin
        grant[REQ_PPU] = 1'b1;
      end else if (req[REQ_CPU]) begin
        grant[REQ_CPU] = 1'b1;
      end else if (req[REQ_HOST]) begin
        grant[REQ_HOST] = 1'b1;
      end
    end
  end

  always_comb begin
    win_we    = 1'b0;
    win_sel   = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        win_we    = we[i];
        win_sel   = sel[3*i +: 3];
        win_addr  = addr[ADDR_W*i +: ADDR_W];
        win_wdata = wdata[8*i +: 8];
      end
    end
    win_legal = sel_legal(win_sel);
  end

  assign ack = grant;

  // NOTE: pipeline valid bits are reset so an operation in flight at reset
  // never produces a late strobe or rvalid; payload registers need no reset
  // beyond what the interface requires.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_rden       <= 1'b0;
      mem_wren       <= 1'b0;
      mem_prg_sel    <= 1'b0;
      mem_chr_sel    <= 1'b0;
      mem_ram_sel    <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      iss_rd_grant   <= '0;
      iss_legal      <= 1'b0;
      ret_rvalid     <= '0;
      ret_legal      <= 1'b0;
      rdata_q        <= '0;
    end else begin
      mem_rden <= (|grant) && win_legal && !win_we;
      mem_wren <= (|grant) && win_legal && win_we;
      {mem_prg_sel, mem_chr_sel, mem_ram_sel} <= ((|grant) && win_legal) ? win_sel : 3'b000;
      if (|grant) begin
        mem_address    <= win_addr;
        mem_write_data <= win_wdata;
      end
      iss_rd_grant <= win_we ? 3'b000 : grant;
      iss_legal    <= win_legal;
      ret_rvalid   <= iss_rd_grant;
      ret_legal    <= iss_legal;
      rdata_q      <= rdata;
    end
  end

  // Read data arrives the cycle after mem_rden, so it is forwarded directly
  // with rvalid and captured to hold afterwards.
  assign rvalid = ret_rvalid;
  assign rdata  = (|ret_rvalid) ? (ret_legal ? mem_read_data : OPEN_BUS) : rdata_q;

`ifdef CART_ARB_STATS_EN
  logic multi_pending;
  assign multi_pending = (req[0] & req[1]) | (req[0] & req[2]) | (req[1] & req[2]);

  always_ff @(posedge clock) begin
    if (reset || stat_clear) begin
      stat_conflicts  <= '0;
      stat_promotions <= '0;
    end else begin
      if (multi_pending && cart_ready && (stat_conflicts != 16'hFFFF))
        stat_conflicts <= stat_conflicts + 16'd1;
      if (win_prom && (stat_promotions != 16'hFFFF))
        stat_promotions <= stat_promotions + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed self-checking bench for cart_mem_arbiter: reset, cart_ready gating,
// read/write timing, starvation promotion, illegal selects and mid-op reset.
module tb_cart_mem_arbiter;
  import cart_arb_pkg::*;

  localparam int ADDR_W = 21;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                cart_ready = 1'b0;
  logic [2:0]          req = '0;
  logic [2:0]          we = '0;
  logic [8:0]          sel = '0;
  logic [3*ADDR_W-1:0] addr = '0;
  logic [23:0]         wdata = '0;
  logic [2:0]          ack, rvalid;
  logic [7:0]          rdata;
  logic [ADDR_W-1:0]   mem_address;
  logic                mem_prg_sel, mem_chr_sel, mem_ram_sel, mem_rden, mem_wren;
  logic [7:0]          mem_write_data;
  logic [7:0]          mem_read_data = '0;
`ifdef CART_ARB_STATS_EN
  logic                stat_clear = 1'b0;
  logic [15:0]         stat_conflicts, stat_promotions;
`endif

  int checks = 0;
  int errors = 0;

  cart_mem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8), .OPEN_BUS(8'hFF)) dut (
    .clock          (clock),
    .reset          (reset),
    .cart_ready     (cart_ready),
    .req            (req),
    .we             (we),
    .sel            (sel),
    .addr           (addr),
    .wdata          (wdata),
    .ack            (ack),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_prg_sel    (mem_prg_sel),
    .mem_chr_sel    (mem_chr_sel),
    .mem_ram_sel    (mem_ram_sel),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
`ifdef CART_ARB_STATS_EN
    ,
    .stat_clear      (stat_clear),
    .stat_conflicts  (stat_conflicts),
    .stat_promotions (stat_promotions)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic setup(input int i, input logic w, input logic [2:0] s,
                       input logic [ADDR_W-1:0] a, input logic [7:0] d);
    we[i]                = w;
    sel[3*i +: 3]        = s;
    addr[ADDR_W*i +: ADDR_W] = a;
    wdata[8*i +: 8]      = d;
  endtask

  initial begin
    // Reset state
    repeat (3) cyc();
    #1;
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_strobes", 32'({mem_rden, mem_wren, mem_prg_sel, mem_chr_sel, mem_ram_sel}), 32'h0);
    check("rst_address", 32'(mem_address), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    reset = 1'b0;

    // cart_ready low blocks every grant; counters must not advance meanwhile
    setup(0, 1'b0, SEL_CHR, 21'h00001, 8'h00);
    setup(1, 1'b0, SEL_CHR, 21'h00002, 8'h00);
    setup(2, 1'b0, SEL_CHR, 21'h00003, 8'h00);
    req = 3'b111;
    for (int i = 0; i < 20; i++) begin
      cyc(); #1;
      check("notready_ack", 32'(ack), 32'h0);
      check("notready_mem", 32'({mem_rden, mem_wren}), 32'h0);
    end
    cyc(); cart_ready = 1'b1; #1;
    check("ready_ack_ppu", 32'(ack), 32'h1);
    cyc(); req = 3'b000; #1;
    check("ready_rden", 32'(mem_rden), 32'h1);
    repeat (3) cyc();

    // PPU read timing
    mem_read_data = 8'h5A;
    setup(0, 1'b0, SEL_CHR, 21'h00010, 8'h00);
    cyc(); req = 3'b001; #1;
    check("rd_ack", 32'(ack), 32'h1);
    cyc(); req = 3'b000; #1;
    check("rd_rden", 32'(mem_rden), 32'h1);
    check("rd_sels", 32'({mem_prg_sel, mem_chr_sel, mem_ram_sel}), 32'h2);
    check("rd_addr", 32'(mem_address), 32'h10);
    check("rd_rvalid_early", 32'(rvalid), 32'h0);
    cyc(); #1;
    check("rd_rvalid", 32'(rvalid), 32'h1);
    check("rd_rdata", 32'(rdata), 32'h5A);
    check("rd_rden_off", 32'(mem_rden), 32'h0);
    cyc(); mem_read_data = 8'h00; #1;
    check("rd_rvalid_off", 32'(rvalid), 32'h0);
    check("rd_rdata_hold", 32'(rdata), 32'h5A);

    // CPU starved by a continuous PPU stream wins after 8 waiting cycles
    setup(1, 1'b0, SEL_PRG, 21'h00200, 8'h00);
    cyc(); req = 3'b011; #1;
    check("starve_ppu_0", 32'(ack), 32'h1);
    for (int i = 1; i < 8; i++) begin
      cyc(); #1;
      check("starve_ppu", 32'(ack), 32'h1);
    end
    cyc(); #1;
    check("starve_cpu_win", 32'(ack), 32'h2);
    cyc(); req = 3'b001; #1;
    check("starve_ppu_resume", 32'(ack), 32'h1);
    cyc(); req = 3'b000;
    repeat (3) cyc();

    // CPU and host promoted together: CPU first, host next
    setup(2, 1'b0, SEL_RAM, 21'h00300, 8'h00);
    cyc(); req = 3'b111; #1;
    check("both_ppu_0", 32'(ack), 32'h1);
    for (int i = 1; i < 8; i++) begin
      cyc(); #1;
      check("both_ppu", 32'(ack), 32'h1);
    end
    cyc(); #1;
    check("both_cpu_first", 32'(ack), 32'h2);
    cyc(); req = 3'b101; #1;
    check("both_host_next", 32'(ack), 32'h4);
    cyc(); req = 3'b001; #1;
    check("both_ppu_resume", 32'(ack), 32'h1);
    cyc(); req = 3'b000;
    repeat (3) cyc();
`ifdef CART_ARB_STATS_EN
    check("stat_conflicts", 32'(stat_conflicts), 32'd20);
    check("stat_promotions", 32'(stat_promotions), 32'd3);
    stat_clear = 1'b1;
    cyc(); stat_clear = 1'b0; #1;
    check("stat_cleared", 32'({stat_conflicts, stat_promotions}), 32'h0);
`endif

    // Illegal select on a host read returns open bus without touching memory
    mem_read_data = 8'h33;
    setup(2, 1'b0, 3'b011, 21'h00007, 8'h00);
    cyc(); req = 3'b100; #1;
    check("illegal_ack", 32'(ack), 32'h4);
    cyc(); req = 3'b000; #1;
    check("illegal_no_strobe", 32'({mem_rden, mem_wren}), 32'h0);
    check("illegal_no_sel", 32'({mem_prg_sel, mem_chr_sel, mem_ram_sel}), 32'h0);
    cyc(); #1;
    check("illegal_rvalid", 32'(rvalid), 32'h4);
    check("illegal_rdata", 32'(rdata), 32'hFF);

    // CPU write followed immediately by a PPU read
    mem_read_data = 8'h6C;
    setup(1, 1'b1, SEL_RAM, 21'h00123, 8'hA7);
    setup(0, 1'b0, SEL_PRG, 21'h00055, 8'h00);
    cyc(); req = 3'b010; #1;
    check("wr_ack", 32'(ack), 32'h2);
    cyc(); req = 3'b001; #1;
    check("wr_ppu_ack", 32'(ack), 32'h1);
    check("wr_wren", 32'({mem_wren, mem_rden}), 32'h2);
    check("wr_data", 32'(mem_write_data), 32'hA7);
    check("wr_ram_sel", 32'({mem_prg_sel, mem_chr_sel, mem_ram_sel}), 32'h1);
    check("wr_addr", 32'(mem_address), 32'h123);
    cyc(); req = 3'b000; #1;
    check("wr_then_rden", 32'({mem_wren, mem_rden}), 32'h1);
    check("wr_then_prg", 32'(mem_prg_sel), 32'h1);
    check("wr_then_addr", 32'(mem_address), 32'h55);
    check("wr_no_rvalid", 32'(rvalid), 32'h0);
    cyc(); #1;
    check("wr_ppu_rvalid", 32'(rvalid), 32'h1);
    check("wr_ppu_rdata", 32'(rdata), 32'h6C);

    // Reset while a read is in flight discards its return
    mem_read_data = 8'h99;
    cyc(); req = 3'b001; #1;
    check("rstmid_ack", 32'(ack), 32'h1);
    cyc(); req = 3'b000; reset = 1'b1; #1;
    check("rstmid_rden", 32'(mem_rden), 32'h1);
    cyc(); reset = 1'b0; #1;
    check("rstmid_no_rvalid", 32'(rvalid), 32'h0);
    check("rstmid_rden_off", 32'(mem_rden), 32'h0);
    check("rstmid_rdata", 32'(rdata), 32'h0);
    cyc(); #1;
    check("rstmid_no_rvalid2", 32'(rvalid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares the single-ported cart memory between three requesters: PPU (index 0), CPU (index 1) and host/debug save-state port (index 2).
- Sits between the requesters and the cart memory's address/select/rden/wren/data port.
- Fixed priority with anti-starvation promotion.
- No grants while the cart is loading (cart_ready low).

Parameters:
- ADDR_W, 21, requester/memory address width.
- STARVE_LIMIT, 8, consecutive cycles a pending, ungranted CPU/host request waits before promotion to top priority.
- OPEN_BUS, 8'hFF, read data returned for illegal select codes.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- cart_ready  in  1  cart memory loaded and usable
- req  in  3  per-requester request, held until ack
- we  in  3  per-requester write (1) / read (0)
- sel  in  9  per-requester {prg,chr,ram} select, requester i at [3i+2:3i]
- addr  in  3*ADDR_W  per-requester address, requester i at [ADDR_W*i +: ADDR_W]
- wdata  in  24  per-requester write byte, requester i at [8i+7:8i]
- ack  out  3  one-cycle pulse: request accepted this cycle
- rvalid  out  3  one-cycle pulse: rdata valid for that requester
- rdata  out  8  read data, broadcast to all requesters
- mem_address  out  ADDR_W  to cart memory
- mem_prg_sel, mem_chr_sel, mem_ram_sel  out  1 each  to cart memory
- mem_rden, mem_wren  out  1 each  to cart memory
- mem_write_data  out  8  to cart memory
- mem_read_data  in  8  from cart memory, valid the cycle after mem_rden

Behaviour:
- Reset: ack, rvalid, all mem_* strobes and selects = 0; mem_address = 0; rdata = 0; starvation counters = 0.
- Arbitration is combinational on req; issue is registered.
  - Cycle N: winner selected; ack[winner] asserted in cycle N.
  - Memory strobes and address driven registered in cycle N+1.
  - Read: rvalid[winner] and rdata in cycle N+2.
  - Requester drops or changes req on the cycle after ack.
- One grant per cycle; back-to-back grants are allowed, giving full throughput.
- A write generates no rvalid.
- Priority:
  - Any promoted requester wins first; if both are promoted, CPU beats host.
  - Otherwise PPU > CPU > host.
- Starvation counters (CPU, host only):
  - Increment each cycle req is high, cart_ready is high and that requester is not granted.
  - Saturate at STARVE_LIMIT; counter value == STARVE_LIMIT means promoted.
  - Clear on grant or when req is low.
- cart_ready low:
  - No acks are issued and starvation counters hold.
  - Already-issued operations complete normally, including their rvalid.
  - cart_ready dropping mid-pipeline does not cancel them.
- Illegal sel (zero or multi-hot):
  - Request is acked; no mem_rden/mem_wren is issued.
  - If a read, rvalid is returned at the normal latency with rdata = OPEN_BUS.
- rdata holds its last value when rvalid is low.
- Reset mid-operation: pending issue/return stages are discarded and no rvalid follows.

Optional Feature:
- Macro CART_ARB_STATS_EN.
- When defined, adds:
  - input stat_clear;
  - output stat_conflicts[15:0]: cycles with at least two requesters pending while cart_ready is high;
  - output stat_promotions[15:0]: count of grants won via promotion.
- Both counters saturate at 16'hFFFF and clear on reset or stat_clear; stat_clear has priority over an increment in the same cycle.
- When undefined, these ports and counters are absent and arbitration behaviour is identical.

Decomposition:
- Package cart_arb_pkg: requester index constants (REQ_PPU=0, REQ_CPU=1, REQ_HOST=2), NUM_REQ=3, select encodings SEL_PRG/SEL_CHR/SEL_RAM, OPEN_BUS default.
- One sub-module cart_arb_starve_ctr: saturating wait counter with promoted output, instantiated for CPU and host.

Test Plan:
- cart_ready=0, all req high for 20 cycles -> no ack, no mem strobes; raise cart_ready -> ack[0] in that cycle.
- PPU read addr 0x00010, sel=chr, mem_read_data=8'h5A -> ack[0] at N, mem_rden+mem_chr_sel at N+1, rvalid[0] with rdata=8'h5A at N+2.
- PPU req held continuously, CPU req held -> CPU acked after exactly STARVE_LIMIT (8) cycles of waiting, then PPU resumes.
- CPU and host both promoted in the same cycle -> CPU acked first; host acked the next cycle.
- Host read with sel=3'b011 -> ack, no mem_rden, rvalid[2] with rdata=8'hFF two cycles later.
- CPU write (wdata=8'hA7, sel=ram) immediately followed by PPU read -> mem_wren and mem_write_data=8'hA7 for one cycle, next cycle mem_rden; no rvalid[1].
